multiport_regfile: RTL and testbench

MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

---
 rtl/multiport_regfile_pkg.sv | 16 +
 rtl/multiport_regfile_array.sv | 46 ++++
 rtl/multiport_regfile.sv | 152 +++++++++++++++
 tb/tb_multiport_regfile.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/multiport_regfile_pkg.sv
// -----------------------------------------------------------------------------
// multiport_regfile_pkg
//   Shared definitions for the multiport register file: default width
//   constants and the clear-sequencer state encoding.
// -----------------------------------------------------------------------------
package multiport_regfile_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/multiport_regfile_array.sv
// -----------------------------------------------------------------------------
// regfile_array
//   Storage array with one synchronous write port and two asynchronous read
//   ports. The array has no reset; the clear sequencer in the parent
//   initialises it.
//
// Ports
//   clk     in   clock
//   we      in   write enable (already qualified by the parent)
//   waddr   in   write address
//   wdata   in   write data
//   raddr1  in   read address, port 1
//   raddr2  in   read address, port 2
//   rdata1  out  combinational read data, port 1
//   rdata2  out  combinational read data, port 2
// -----------------------------------------------------------------------------
module regfile_array
  import multiport_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata1 = mem_q[raddr1];
  assign rdata2 = mem_q[raddr2];

endmodule

// File: rtl/multiport_regfile.sv
// -----------------------------------------------------------------------------
// multiport_regfile
//   Two-read / one-write register file with registered read data, same-cycle
//   write-through bypass, optional hard-wired entry 0 and a clear sequencer
//   that walks every entry after reset or on request.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_CLEAR | sequencer owns the array, writes CLR_VAL to entry cnt_q
//   ST_IDLE  | normal operation: reads, writes, accepts clr
//
// Ports
//   clk     in   clock
//   rst_n   in   synchronous active-low reset
//   rd_en   in   read enable; outputs hold when low
//   raddr1  in   read address, port 1
//   raddr2  in   read address, port 2
//   we      in   write enable
//   waddr   in   write address
//   wdata   in   write data
//   clr     in   request a full clear (accepted only in ST_IDLE)
//   rdata1  out  registered read data, port 1
//   rdata2  out  registered read data, port 2
//   busy    out  high while the clear sequencer runs
// -----------------------------------------------------------------------------
module multiport_regfile
  import multiport_regfile_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] CLR_VAL  = '0,
  parameter bit                ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy
);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [DATA_W-1:0] rdata2_q, rdata2_d;
  logic              busy_q, busy_d;

  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rd1, arr_rd2;

  // Read-data selection: hard-wired entry 0 wins over bypass, bypass wins
  // over the stored value.
  function automatic logic [DATA_W-1:0] read_sel(
    input logic [ADDR_W-1:0] raddr,
    input logic [DATA_W-1:0] arr_val,
    input logic              wr_en,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data
  );
    if (ZERO_REG && (raddr == '0)) begin
      return CLR_VAL;
    end else if (wr_en && (raddr == wr_addr)) begin
      return wr_data;
    end else begin
      return arr_val;
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata1_d  = rdata1_q;
    rdata2_d  = rdata2_q;
    arr_we    = 1'b0;
    arr_waddr = waddr;
    arr_wdata = wdata;

    case (state_q)
      ST_CLEAR: begin
        arr_we    = 1'b1;
        arr_waddr = cnt_q;
        arr_wdata = CLR_VAL;
        cnt_d     = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        arr_we = we && !(ZERO_REG && (waddr == '0));
        if (rd_en) begin
          rdata1_d = read_sel(raddr1, arr_rd1, we, waddr, wdata);
          rdata2_d = read_sel(raddr2, arr_rd2, we, waddr, wdata);
        end
        // The write above still lands this cycle; the clear then overwrites it.
        if (clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d == ST_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_CLEAR;
      cnt_q    <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      busy_q   <= busy_d;
    end
  end

  // Reset must also squash the array write of that cycle.
  regfile_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk    (clk),
    .we     (arr_we && rst_n),
    .waddr  (arr_waddr),
    .wdata  (arr_wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (arr_rd1),
    .rdata2 (arr_rd2)
  );

  assign rdata1 = rdata1_q;
  assign rdata2 = rdata2_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_multiport_regfile.sv
// -----------------------------------------------------------------------------
// tb_multiport_regfile
//   Three instances share one stimulus stream:
//     inst 0: ZERO_REG=0, CLR_VAL=8'h00
//     inst 1: ZERO_REG=1, CLR_VAL=8'h00
//     inst 2: ZERO_REG=1, CLR_VAL=8'hC3
//   The driver updates a behavioural model and queues the expected outputs;
//   the monitor pops one entry per clock and compares.
// -----------------------------------------------------------------------------
module tb_multiport_regfile;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int NI    = 3;

  logic          clk;
  logic          rst_n;
  logic          rd_en;
  logic [AW-1:0] raddr1, raddr2;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          clr;

  logic [DW-1:0] o_r1 [NI];
  logic [DW-1:0] o_r2 [NI];
  logic          o_busy [NI];

  multiport_regfile #(.DATA_W(DW), .ADDR_W(AW), .CLR_VAL(8'h00), .ZERO_REG(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .raddr1(raddr1), .raddr2(raddr2),
    .we(we), .waddr(waddr), .wdata(wdata), .clr(clr),
    .rdata1(o_r1[0]), .rdata2(o_r2[0]), .busy(o_busy[0]));

  multiport_regfile #(.DATA_W(DW), .ADDR_W(AW), .CLR_VAL(8'h00), .ZERO_REG(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .raddr1(raddr1), .raddr2(raddr2),
    .we(we), .waddr(waddr), .wdata(wdata), .clr(clr),
    .rdata1(o_r1[1]), .rdata2(o_r2[1]), .busy(o_busy[1]));

  multiport_regfile #(.DATA_W(DW), .ADDR_W(AW), .CLR_VAL(8'hC3), .ZERO_REG(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .raddr1(raddr1), .raddr2(raddr2),
    .we(we), .waddr(waddr), .wdata(wdata), .clr(clr),
    .rdata1(o_r1[2]), .rdata2(o_r2[2]), .busy(o_busy[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [NI-1:0][DW-1:0] r1;
    logic [NI-1:0][DW-1:0] r2;
    logic [NI-1:0]         b;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  // Reference model: contents, cycles of clearing left, expected outputs.
  logic [DW-1:0] mm    [NI][DEPTH];
  int            left  [NI];
  logic [DW-1:0] m_r1  [NI];
  logic [DW-1:0] m_r2  [NI];
  bit            zr    [NI];
  logic [DW-1:0] cv    [NI];

  function automatic logic [DW-1:0] model_read(input int k, input logic [AW-1:0] ra,
                                               input logic w, input logic [AW-1:0] wa,
                                               input logic [DW-1:0] wd);
    if (zr[k] && ra == 0) return cv[k];
    if (w && ra == wa) return wd;
    return mm[k][ra];
  endfunction

  task automatic apply(input logic i_rst_n, input logic i_rd_en,
                       input logic [AW-1:0] i_ra1, input logic [AW-1:0] i_ra2,
                       input logic i_we, input logic [AW-1:0] i_wa,
                       input logic [DW-1:0] i_wd, input logic i_clr);
    exp_t e;
    logic [DW-1:0] v1, v2;
    @(negedge clk);
    rst_n  = i_rst_n;
    rd_en  = i_rd_en;
    raddr1 = i_ra1;
    raddr2 = i_ra2;
    we     = i_we;
    waddr  = i_wa;
    wdata  = i_wd;
    clr    = i_clr;
    for (int k = 0; k < NI; k++) begin
      if (!i_rst_n) begin
        left[k] = DEPTH;
        m_r1[k] = '0;
        m_r2[k] = '0;
      end else if (left[k] > 0) begin
        mm[k][DEPTH - left[k]] = cv[k];
        left[k] = left[k] - 1;
      end else begin
        v1 = model_read(k, i_ra1, i_we, i_wa, i_wd);
        v2 = model_read(k, i_ra2, i_we, i_wa, i_wd);
        if (i_rd_en) begin
          m_r1[k] = v1;
          m_r2[k] = v2;
        end
        if (i_we && !(zr[k] && i_wa == 0)) mm[k][i_wa] = i_wd;
        if (i_clr) left[k] = DEPTH;
      end
      e.r1[k] = m_r1[k];
      e.r2[k] = m_r2[k];
      e.b[k]  = (left[k] > 0);
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    apply(1'b1, 1'b1, a1, a2, 1'b0, 4'd0, 8'h00, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    apply(1'b1, 1'b0, 4'd0, 4'd0, 1'b1, a, d, 1'b0);
  endtask

  // Monitor: one expected entry per clock, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < NI; k++) begin
          vectors++;
          if (o_r1[k] !== e.r1[k]) begin
            miscompares++;
            $display("FAIL rdata1 inst%0d t=%0t got %h expected %h", k, $time, o_r1[k], e.r1[k]);
          end
          vectors++;
          if (o_r2[k] !== e.r2[k]) begin
            miscompares++;
            $display("FAIL rdata2 inst%0d t=%0t got %h expected %h", k, $time, o_r2[k], e.r2[k]);
          end
          vectors++;
          if (o_busy[k] !== e.b[k]) begin
            miscompares++;
            $display("FAIL busy inst%0d t=%0t got %b expected %b", k, $time, o_busy[k], e.b[k]);
          end
        end
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    zr[0] = 1'b0; cv[0] = 8'h00;
    zr[1] = 1'b1; cv[1] = 8'h00;
    zr[2] = 1'b1; cv[2] = 8'hC3;
    for (int k = 0; k < NI; k++) begin
      left[k] = DEPTH;
      m_r1[k] = '0;
      m_r2[k] = '0;
      for (int a = 0; a < DEPTH; a++) mm[k][a] = '0;
    end
    rst_n = 1'b0; rd_en = 1'b0; raddr1 = '0; raddr2 = '0;
    we = 1'b0; waddr = '0; wdata = '0; clr = 1'b0;

    // Reset for two cycles, then the post-reset clear pass.
    apply(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0);
    apply(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0);
    idle(18);
    for (int a = 0; a < DEPTH; a++) rd(4'(a), 4'(DEPTH - 1 - a));

    // Write then read next cycle.
    wr(4'd3, 8'hA5);
    rd(4'd3, 4'd4);

    // Same-cycle write-through on both ports.
    apply(1'b1, 1'b1, 4'd7, 4'd7, 1'b1, 4'd7, 8'h3C, 1'b0);
    rd(4'd7, 4'd3);

    // Hold while clearing; writes during the clear are lost.
    wr(4'd2, 8'h11);
    rd(4'd2, 4'd2);
    apply(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b1);
    for (int i = 0; i < DEPTH; i++)
      apply(1'b1, 1'b0, 4'd5, 4'd6, 1'b1, 4'(i), 8'hE0 + 8'(i), 1'b0);
    idle(1);
    rd(4'd2, 4'd9);
    rd(4'd15, 4'd0);

    // Entry 0: write and read same cycle, then next cycle.
    apply(1'b1, 1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 8'hFF, 1'b0);
    rd(4'd0, 4'd0);

    // Reset at clear index 9.
    apply(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b1);
    idle(9);
    apply(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd1, 8'h77, 1'b0);
    idle(18);

    // Write and clear together: clear wins in the end.
    wr(4'd5, 8'h5A);
    apply(1'b1, 1'b1, 4'd5, 4'd5, 1'b1, 4'd5, 8'h99, 1'b1);
    idle(17);
    rd(4'd5, 4'd5);

    // Randomised traffic.
    for (int i = 0; i < 500; i++) begin
      apply(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 3) != 0),
            4'($urandom_range(0, DEPTH - 1)),
            4'($urandom_range(0, DEPTH - 1)),
            1'($urandom_range(0, 1)),
            4'($urandom_range(0, DEPTH - 1)),
            8'($urandom),
            ($urandom_range(0, 39) == 0));
    end

    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
